// File: rtl/cpu31_pkg.sv
// rtl/cpu31_pkg.sv - shared constants for the EX-stage divider
package cpu31_pkg;

    // Operand/result width of the integer divider.
    localparam int DIV_WIDTH = 32;

    // Divider FSM state encoding.
    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_RUN  = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;

    // Quotient reported for a division by zero.
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   rem          partial remainder before this step (always < divisor)
//   dividend_msb next dividend bit shifted into the remainder
//   divisor      divisor magnitude
//   rem_next     partial remainder after this step
//   qbit         quotient bit produced by this step
import cpu31_pkg::*;

module div_step #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dividend_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    // The shifted remainder is kept one bit wider so that divisors with
    // the MSB set still compare correctly in unsigned mode.
    assign rem_shift = {rem, dividend_msb};
    assign diff      = rem_shift - {1'b0, divisor};

    // No borrow means rem_shift >= divisor.
    assign qbit      = ~diff[WIDTH];
    assign rem_next  = qbit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned integer divider (DIV/DIVU)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   start     request a division, sampled only while idle
//   sign      1 = signed (DIV), 0 = unsigned (DIVU)
//   a, b      dividend, divisor
//   q, r      quotient (LO), remainder (HI), held until the next result
//   busy      high while a division is in progress or completing
//   done      one-cycle pulse, q/r valid
//   div_zero  last division had b == 0
import cpu31_pkg::*;

module div_unit #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvd;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs;      // divisor magnitude
    logic [WIDTH-1:0] rem;      // partial remainder
    logic             neg_q;
    logic             neg_r;
    logic             zero;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] rem_next;
    logic             qbit;

    assign a_neg = sign & a[WIDTH-1];
    assign b_neg = sign & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem          (rem),
        .dividend_msb (dvd[WIDTH-1]),
        .divisor      (dvs),
        .rem_next     (rem_next),
        .qbit         (qbit)
    );

    assign busy = (state != DIV_IDLE);
    assign done = (state == DIV_DONE);

    // RUN performs one step per cycle while count is non-zero; the cycle
    // with count == 0 applies sign correction and enters DONE. A division
    // by zero enters RUN with count == 0, so it only spends that final cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= DIV_IDLE;
            count    <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero     <= 1'b0;
            q        <= '0;
            r        <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        state <= DIV_RUN;
                        neg_q <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r <= a_neg;
                        rem   <= '0;
                        dvs   <= b_mag;
                        if (b == '0) begin
                            zero  <= 1'b1;
                            dvd   <= a;     // raw dividend becomes r
                            count <= '0;
                        end else begin
                            zero  <= 1'b0;
                            dvd   <= a_mag;
                            count <= CW'(WIDTH);
                        end
                    end
                end
                DIV_RUN: begin
                    if (count != '0) begin
                        rem   <= rem_next;
                        dvd   <= {dvd[WIDTH-2:0], qbit};
                        count <= count - 1'b1;
                    end else begin
                        state <= DIV_DONE;
                        if (zero) begin
                            q        <= {WIDTH{1'b1}};
                            r        <= dvd;
                            div_zero <= 1'b1;
                        end else begin
                            q        <= neg_q ? (~dvd + 1'b1) : dvd;
                            r        <= neg_r ? (~rem + 1'b1) : rem;
                            div_zero <= 1'b0;
                        end
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

endmodule
